// File: rtl/alsu_pipe.sv
// Parametrised ALSU with a valid/ready front end, a shift-add multiplier and an LED blink on invalid ops.
// Handles one operation at a time. in_ready is high only while the block is idle.
module alsu_pipe #(
    parameter int    WIDTH          = 4,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON",
    parameter int    BLINK_CYCLES   = 6,
    parameter int    LED_W          = 16
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           opcode,
    input  logic                 cin,
    input  logic                 serial_in,
    input  logic                 direction,
    input  logic                 red_op_A,
    input  logic                 red_op_B,
    input  logic                 bypass_A,
    input  logic                 bypass_B,
    output logic [2*WIDTH-1:0]   out,
    output logic                 out_valid,
    output logic                 err,
    output logic [LED_W-1:0]     leds
);

    localparam int OUT_W   = 2 * WIDTH;
    localparam bit PRIO_B  = (INPUT_PRIORITY == "B");
    localparam bit USE_CIN = (FULL_ADDER != "OFF");

    // One counter serves both the multiplier iterations and the blink sequence.
    localparam int CNT_MAX = (WIDTH > BLINK_CYCLES) ? WIDTH : BLINK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_EXEC  = 2'd1;
    localparam logic [1:0] S_MUL   = 2'd2;
    localparam logic [1:0] S_ERROR = 2'd3;

    localparam logic [2:0] OP_AND    = 3'b000;
    localparam logic [2:0] OP_XOR    = 3'b001;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_MULT   = 3'b011;
    localparam logic [2:0] OP_SHIFT  = 3'b100;
    localparam logic [2:0] OP_ROTATE = 3'b101;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic             r_cin;
    logic             r_si;
    logic             r_dir;
    logic             r_redA;
    logic             r_redB;
    logic             r_bypA;
    logic             r_bypB;
    logic [CNT_W-1:0] r_cnt;
    logic [OUT_W-1:0] r_prod;
    logic [OUT_W-1:0] r_mcand;

    logic             w_isBypass;
    logic             w_isInvalid;
    logic             w_carry;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_redOperand;
    logic [WIDTH-1:0] w_bypOperand;
    logic [OUT_W-1:0] w_addend;
    logic [OUT_W-1:0] w_prodNext;
    logic [OUT_W-1:0] w_execResult;

    assign in_ready = (r_state == S_IDLE);

    // Decode is evaluated on the raw inputs so the next state is known at the accept edge.
    assign w_isBypass  = bypass_A | bypass_B;
    assign w_isInvalid = (opcode[2:1] == 2'b11) ||
                         ((red_op_A | red_op_B) && (opcode[2:1] != 2'b00));

    assign w_carry      = USE_CIN ? r_cin : 1'b0;
    assign w_sum        = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, w_carry};
    assign w_redOperand = (r_redA && r_redB) ? (PRIO_B ? r_b : r_a) : (r_redA ? r_a : r_b);
    assign w_bypOperand = (r_bypA && r_bypB) ? (PRIO_B ? r_b : r_a) : (r_bypA ? r_a : r_b);

    // Multiplier consumes the LSB of the shifting multiplier against a left-shifting multiplicand.
    assign w_addend   = r_b[0] ? r_mcand : '0;
    assign w_prodNext = r_prod + w_addend;

    always_comb begin
        w_execResult = '0;
        if (r_bypA || r_bypB) begin
            w_execResult = {{WIDTH{1'b0}}, w_bypOperand};
        end else begin
            case (r_op)
                OP_AND: begin
                    if (r_redA || r_redB)
                        w_execResult = {{(OUT_W-1){1'b0}}, &w_redOperand};
                    else
                        w_execResult = {{WIDTH{1'b0}}, r_a & r_b};
                end
                OP_XOR: begin
                    if (r_redA || r_redB)
                        w_execResult = {{(OUT_W-1){1'b0}}, ^w_redOperand};
                    else
                        w_execResult = {{WIDTH{1'b0}}, r_a ^ r_b};
                end
                OP_ADD: begin
                    w_execResult = {{(WIDTH-1){1'b0}}, w_sum};
                end
                OP_SHIFT: begin
                    if (r_dir)
                        w_execResult = {out[OUT_W-2:0], r_si};
                    else
                        w_execResult = {r_si, out[OUT_W-1:1]};
                end
                OP_ROTATE: begin
                    if (r_dir)
                        w_execResult = {out[OUT_W-2:0], out[OUT_W-1]};
                    else
                        w_execResult = {out[0], out[OUT_W-1:1]};
                end
                default: begin
                    w_execResult = out;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_cin     <= 1'b0;
            r_si      <= 1'b0;
            r_dir     <= 1'b0;
            r_redA    <= 1'b0;
            r_redB    <= 1'b0;
            r_bypA    <= 1'b0;
            r_bypB    <= 1'b0;
            r_cnt     <= '0;
            r_prod    <= '0;
            r_mcand   <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            err       <= 1'b0;
            leds      <= '0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a    <= A;
                        r_b    <= B;
                        r_op   <= opcode;
                        r_cin  <= cin;
                        r_si   <= serial_in;
                        r_dir  <= direction;
                        r_redA <= red_op_A;
                        r_redB <= red_op_B;
                        r_bypA <= bypass_A;
                        r_bypB <= bypass_B;
                        r_cnt  <= '0;
                        if (w_isBypass) begin
                            r_state <= S_EXEC;
                        end else if (w_isInvalid) begin
                            r_state <= S_ERROR;
                            out     <= '0;
                            leds    <= '1;
                            err     <= 1'b1;
                        end else if (opcode == OP_MULT) begin
                            r_state <= S_MUL;
                            r_prod  <= '0;
                            r_mcand <= {{WIDTH{1'b0}}, A};
                        end else begin
                            r_state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    out       <= w_execResult;
                    out_valid <= 1'b1;
                    r_state   <= S_IDLE;
                end
                S_MUL: begin
                    r_prod  <= w_prodNext;
                    r_mcand <= r_mcand << 1;
                    r_b     <= r_b >> 1;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        out       <= w_prodNext;
                        out_valid <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                S_ERROR: begin
                    if (r_cnt == CNT_W'(BLINK_CYCLES - 1)) begin
                        leds    <= '0;
                        err     <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        leds  <= ~leds;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alsu_pipe.sv
// Self-checking bench for alsu_pipe: directed vector table, randomized ops against a reference model,
// and hand sequences for reset during MUL/ERROR. Two instances cover both priority/adder settings.
module tb_alsu_pipe;

    localparam int W     = 4;
    localparam int OW    = 2 * W;
    localparam int BLINK = 6;
    localparam int LW    = 16;

    localparam int K_EXEC = 0;
    localparam int K_MUL  = 1;
    localparam int K_ERR  = 2;

    logic          CLK = 1'b0;
    logic          RST_n;
    logic          in_valid;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [2:0]    opcode;
    logic          cin;
    logic          serial_in;
    logic          direction;
    logic          red_op_A;
    logic          red_op_B;
    logic          bypass_A;
    logic          bypass_B;

    logic          in_ready1, out_valid1, err1;
    logic [OW-1:0] out1;
    logic [LW-1:0] leds1;
    logic          in_ready2, out_valid2, err2;
    logic [OW-1:0] out2;
    logic [LW-1:0] leds2;

    int checks = 0;
    int errors = 0;
    logic [OW-1:0] expOut1 = '0;
    logic [OW-1:0] expOut2 = '0;

    typedef struct {
        logic [2:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          cin, si, dir, ra, rb, ba, bb;
        int            kind;
        logic [OW-1:0] exp1;
        logic [OW-1:0] exp2;
    } vec_t;

    alsu_pipe #(.WIDTH(W), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"),
                .BLINK_CYCLES(BLINK), .LED_W(LW)) dut (
        .CLK(CLK), .RST_n(RST_n), .in_valid(in_valid), .in_ready(in_ready1),
        .A(A), .B(B), .opcode(opcode), .cin(cin), .serial_in(serial_in),
        .direction(direction), .red_op_A(red_op_A), .red_op_B(red_op_B),
        .bypass_A(bypass_A), .bypass_B(bypass_B), .out(out1),
        .out_valid(out_valid1), .err(err1), .leds(leds1)
    );

    alsu_pipe #(.WIDTH(W), .INPUT_PRIORITY("B"), .FULL_ADDER("OFF"),
                .BLINK_CYCLES(BLINK), .LED_W(LW)) dut2 (
        .CLK(CLK), .RST_n(RST_n), .in_valid(in_valid), .in_ready(in_ready2),
        .A(A), .B(B), .opcode(opcode), .cin(cin), .serial_in(serial_in),
        .direction(direction), .red_op_A(red_op_A), .red_op_B(red_op_B),
        .bypass_A(bypass_A), .bypass_B(bypass_B), .out(out2),
        .out_valid(out_valid2), .err(err2), .leds(leds2)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic c, input logic si, input logic dir,
                                input logic ra, input logic rb, input logic ba, input logic bb,
                                input int kind, input logic [OW-1:0] e1, input logic [OW-1:0] e2);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.cin = c; v.si = si; v.dir = dir;
        v.ra = ra; v.rb = rb; v.ba = ba; v.bb = bb;
        v.kind = kind; v.exp1 = e1; v.exp2 = e2;
        return v;
    endfunction

    // Reference model: results from the operation rules in plain integer arithmetic.
    function automatic void model(input vec_t v, input logic [OW-1:0] cur, input bit prioB,
                                  input bit fullAdd, output int kind, output logic [OW-1:0] res);
        int a, b, c, r, x, m;
        a = int'(v.a);
        b = int'(v.b);
        c = int'(cur);
        m = 1 << OW;
        r = 0;
        if (v.ba || v.bb) begin
            kind = K_EXEC;
            if (v.ba && v.bb) r = prioB ? b : a;
            else              r = v.ba ? a : b;
        end else if (v.op >= 3'd6 || ((v.ra || v.rb) && v.op >= 3'd2)) begin
            kind = K_ERR;
            r = 0;
        end else if (v.op == 3'd3) begin
            kind = K_MUL;
            r = a * b;
        end else begin
            kind = K_EXEC;
            if (v.ra && v.rb) x = prioB ? b : a;
            else              x = v.ra ? a : b;
            case (v.op)
                3'd0: r = (v.ra || v.rb) ? ((x == (1 << W) - 1) ? 1 : 0) : (a & b);
                3'd1: r = (v.ra || v.rb) ? ($countones(x) % 2) : (a ^ b);
                3'd2: r = a + b + (fullAdd ? int'(v.cin) : 0);
                3'd4: r = v.dir ? ((c * 2) % m + int'(v.si)) : (c / 2 + int'(v.si) * (m / 2));
                default: r = v.dir ? ((c * 2) % m + c / (m / 2)) : (c / 2 + (c % 2) * (m / 2));
            endcase
        end
        res = OW'(r);
    endfunction

    task automatic setInputs(input vec_t v);
        A = v.a; B = v.b; opcode = v.op; cin = v.cin; serial_in = v.si;
        direction = v.dir; red_op_A = v.ra; red_op_B = v.rb;
        bypass_A = v.ba; bypass_B = v.bb;
    endtask

    task automatic driveJunk();
        in_valid = 1'b1;
        A = W'($urandom); B = W'($urandom); opcode = 3'($urandom);
        cin = 1'($urandom); serial_in = 1'($urandom); direction = 1'($urandom);
        red_op_A = 1'($urandom); red_op_B = 1'($urandom);
        bypass_A = 1'($urandom); bypass_B = 1'($urandom);
    endtask

    // Accepts one op from IDLE and checks every cycle until the block is idle again.
    task automatic applyStimulus(input vec_t v);
        checkOutput("ready_before", 32'(in_ready1), 1);
        setInputs(v);
        in_valid = 1'b1;
        @(posedge CLK); #1;
        if (v.kind == K_EXEC) begin
            checkOutput("exec_busy", 32'(in_ready1), 0);
            checkOutput("exec_no_early_valid", 32'(out_valid1), 0);
            driveJunk();
            @(posedge CLK); #1;
            in_valid = 1'b0;
            checkOutput("exec_valid", 32'(out_valid1), 1);
            checkOutput("exec_out", 32'(out1), 32'(v.exp1));
            checkOutput("exec_out_cfg2", 32'(out2), 32'(v.exp2));
            checkOutput("exec_err", 32'(err1), 0);
            checkOutput("exec_ready_after", 32'(in_ready1), 1);
            expOut1 = v.exp1;
            expOut2 = v.exp2;
            @(posedge CLK); #1;
            checkOutput("exec_pulse_end", 32'(out_valid1), 0);
        end else if (v.kind == K_MUL) begin
            for (int k = 0; k < W; k++) begin
                checkOutput("mul_busy", 32'(in_ready1), 0);
                checkOutput("mul_no_valid", 32'(out_valid1), 0);
                checkOutput("mul_out_held", 32'(out1), 32'(expOut1));
                checkOutput("mul_out_held_cfg2", 32'(out2), 32'(expOut2));
                driveJunk();
                @(posedge CLK); #1;
            end
            in_valid = 1'b0;
            checkOutput("mul_valid", 32'(out_valid1), 1);
            checkOutput("mul_out", 32'(out1), 32'(v.exp1));
            checkOutput("mul_ready_after", 32'(in_ready1), 1);
            expOut1 = v.exp1;
            expOut2 = v.exp2;
        end else begin
            for (int k = 0; k < BLINK; k++) begin
                checkOutput("err_flag", 32'(err1), 1);
                checkOutput("err_leds", 32'(leds1), (k % 2 == 0) ? 32'hFFFF : 32'h0);
                checkOutput("err_out", 32'(out1), 0);
                checkOutput("err_no_valid", 32'(out_valid1), 0);
                checkOutput("err_busy", 32'(in_ready1), 0);
                driveJunk();
                @(posedge CLK); #1;
            end
            in_valid = 1'b0;
            checkOutput("err_cleared", 32'(err1), 0);
            checkOutput("err_leds_off", 32'(leds1), 0);
            checkOutput("err_ready_after", 32'(in_ready1), 1);
            checkOutput("err_no_valid_end", 32'(out_valid1), 0);
            expOut1 = '0;
            expOut2 = '0;
        end
    endtask

    initial begin
        vec_t tbl[13];
        vec_t v;
        int kind1, kind2;
        logic [OW-1:0] r1, r2;

        tbl[0]  = mk(3'b010, 4'd7,  4'd9,  1, 0, 0, 0, 0, 0, 0, K_EXEC, 8'h11, 8'h10);
        tbl[1]  = mk(3'b011, 4'd15, 4'd15, 0, 0, 0, 0, 0, 0, 0, K_MUL,  8'hE1, 8'hE1);
        tbl[2]  = mk(3'b110, 4'd5,  4'd6,  0, 0, 0, 0, 0, 0, 0, K_ERR,  8'h00, 8'h00);
        tbl[3]  = mk(3'b010, 4'd5,  4'd6,  0, 0, 0, 1, 0, 0, 0, K_ERR,  8'h00, 8'h00);
        tbl[4]  = mk(3'b000, 4'd3,  4'd5,  0, 0, 0, 0, 0, 1, 1, K_EXEC, 8'h03, 8'h05);
        tbl[5]  = mk(3'b001, 4'd0,  4'b0111, 0, 0, 0, 0, 1, 0, 0, K_EXEC, 8'h01, 8'h01);
        tbl[6]  = mk(3'b011, 4'd9,  4'd5,  0, 0, 0, 0, 0, 0, 0, K_MUL,  8'h2D, 8'h2D);
        tbl[7]  = mk(3'b100, 4'd0,  4'd0,  0, 1, 1, 0, 0, 0, 0, K_EXEC, 8'h5B, 8'h5B);
        tbl[8]  = mk(3'b101, 4'd0,  4'd0,  0, 0, 0, 0, 0, 0, 0, K_EXEC, 8'hAD, 8'hAD);
        tbl[9]  = mk(3'b000, 4'hF,  4'h0,  0, 0, 0, 1, 1, 0, 0, K_EXEC, 8'h01, 8'h00);
        tbl[10] = mk(3'b111, 4'h2,  4'hC,  0, 0, 0, 0, 0, 0, 1, K_EXEC, 8'h0C, 8'h0C);
        tbl[11] = mk(3'b010, 4'hF,  4'hF,  1, 0, 0, 0, 0, 0, 0, K_EXEC, 8'h1F, 8'h1E);
        tbl[12] = mk(3'b011, 4'hA,  4'h0,  0, 0, 0, 0, 0, 0, 0, K_MUL,  8'h00, 8'h00);

        RST_n = 1'b0;
        in_valid = 1'b0;
        setInputs(mk(3'b000, 4'd0, 4'd0, 0, 0, 0, 0, 0, 0, 0, K_EXEC, 8'h0, 8'h0));
        #12;
        checkOutput("reset_out", 32'(out1), 0);
        checkOutput("reset_valid", 32'(out_valid1), 0);
        checkOutput("reset_err", 32'(err1), 0);
        checkOutput("reset_leds", 32'(leds1), 0);
        checkOutput("reset_ready", 32'(in_ready1), 1);
        @(posedge CLK); #1;
        RST_n = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < 13; i++) applyStimulus(tbl[i]);

        for (int i = 0; i < 60; i++) begin
            v = mk(3'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), ($urandom_range(4) == 0), ($urandom_range(4) == 0),
                   ($urandom_range(7) == 0), ($urandom_range(7) == 0), K_EXEC, '0, '0);
            model(v, expOut1, 1'b0, 1'b1, kind1, r1);
            model(v, expOut2, 1'b1, 1'b0, kind2, r2);
            v.kind = kind1;
            v.exp1 = r1;
            v.exp2 = r2;
            applyStimulus(v);
        end

        // Reset in the middle of a multiply: no result may appear afterwards.
        applyStimulus(mk(3'b000, 4'hB, 4'h0, 0, 0, 0, 0, 0, 1, 0, K_EXEC, 8'h0B, 8'h0B));
        setInputs(mk(3'b011, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0, 0, K_MUL, 8'h0, 8'h0));
        in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST_n = 1'b0;
        #1;
        checkOutput("mulrst_out", 32'(out1), 0);
        checkOutput("mulrst_leds", 32'(leds1), 0);
        checkOutput("mulrst_ready", 32'(in_ready1), 1);
        checkOutput("mulrst_valid", 32'(out_valid1), 0);
        @(posedge CLK); #1;
        RST_n = 1'b1;
        expOut1 = '0;
        expOut2 = '0;
        for (int k = 0; k < W + 2; k++) begin
            @(posedge CLK); #1;
            checkOutput("mulrst_no_pulse", 32'(out_valid1), 0);
            checkOutput("mulrst_out_hold", 32'(out1), 0);
            checkOutput("mulrst_ready_idle", 32'(in_ready1), 1);
        end

        // Reset during the blink sequence clears err and leds immediately.
        setInputs(mk(3'b110, 4'd1, 4'd1, 0, 0, 0, 0, 0, 0, 0, K_ERR, 8'h0, 8'h0));
        in_valid = 1'b1;
        @(posedge CLK); #1;
        in_valid = 1'b0;
        @(posedge CLK); #1;
        RST_n = 1'b0;
        #1;
        checkOutput("errrst_err", 32'(err1), 0);
        checkOutput("errrst_leds", 32'(leds1), 0);
        checkOutput("errrst_ready", 32'(in_ready1), 1);
        @(posedge CLK); #1;
        RST_n = 1'b1;
        @(posedge CLK); #1;
        applyStimulus(mk(3'b001, 4'b1100, 4'b1010, 0, 0, 0, 0, 0, 0, 0, K_EXEC, 8'h06, 8'h06));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
